// File: rtl/calc_pkg.sv
// Shared calculator constants: result width, display digit count, BCD digit width, converter states.
// Pure declarations; no timing or backpressure of its own.
package calc_pkg;

    localparam int C_RESULT_W = 17;
    localparam int SSD_DIGITS = 6;
    localparam int DIGIT_W    = 4;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
    localparam logic [1:0] ST_DONE_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_SHIFT = ST_SHIFT_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_e;

endpackage

// File: rtl/calc_bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the next shift.
// Purely combinational, zero latency, no flow control.
module calc_bcd_digit_adj
    import calc_pkg::*;
(
    input  logic [DIGIT_W-1:0] d_in,
    output logic [DIGIT_W-1:0] d_out
);

    always_comb begin
        d_out = d_in;
        if (d_in >= 4'd5) begin
            d_out = d_in + 4'd3;
        end
    end

endmodule

// File: rtl/calc_bin2bcd_seq.sv
// Sequential binary-to-BCD converter with sign, leading-zero blank mask and overflow flag.
// Start accepted in IDLE only; Done pulses W+1 cycles later; Start while Busy is dropped, not queued.
module calc_bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int W      = C_RESULT_W,
    parameter int DIGITS = SSD_DIGITS,
    parameter int SIGNED = 0
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [W-1:0]            Bin,
    output logic                    Busy,
    output logic                    Done,
    output logic [DIGIT_W*DIGITS-1:0] Bcd,
    output logic [DIGITS-1:0]       Blank,
    output logic                    Neg,
    output logic                    Ovf
);

    localparam int BW = DIGIT_W * DIGITS;
    localparam int WW = BW + W;
    localparam int CW = $clog2(W + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    state_e              state_q, state_d;
    logic [BW-1:0]       work_bcd_q, work_bcd_d;
    logic [W-1:0]        mag_q, mag_d;
    logic                sign_q, sign_d;
    logic                ovf_acc_q, ovf_acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic                neg_q, neg_d;
    logic                ovf_q, ovf_d;

    logic [BW-1:0]       adj_bcd;
    logic [WW:0]         shift_w;
    logic [BW-1:0]       bcd_n;
    logic [W-1:0]        mag_n;
    logic                shift_out;
    logic [DIGITS-1:0]   blank_n;
    logic                zero_above;
    logic [W-1:0]        mag_in;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        calc_bcd_digit_adj u_adj (
            .d_in  (work_bcd_q[g*DIGIT_W +: DIGIT_W]),
            .d_out (adj_bcd[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        // The extra top bit of shift_w captures what falls off the last digit.
        shift_w   = {1'b0, adj_bcd, mag_q} << 1;
        shift_out = shift_w[WW];
        bcd_n     = shift_w[WW-1:W];
        mag_n     = shift_w[W-1:0];

        blank_n    = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (bcd_n[i*DIGIT_W +: DIGIT_W] == '0);
            blank_n[i] = zero_above;
        end

        mag_in = ((SIGNED != 0) && Bin[W-1]) ? (~Bin + {{(W-1){1'b0}}, 1'b1}) : Bin;
    end

    always_comb begin
        state_d    = state_q;
        work_bcd_d = work_bcd_q;
        mag_d      = mag_q;
        sign_d     = sign_q;
        ovf_acc_d  = ovf_acc_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        blank_d    = blank_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d    = ST_SHIFT;
                    busy_d     = 1'b1;
                    mag_d      = mag_in;
                    sign_d     = (SIGNED != 0) && Bin[W-1];
                    work_bcd_d = '0;
                    ovf_acc_d  = 1'b0;
                    cnt_d      = CW'(W);
                end
            end
            ST_SHIFT: begin
                work_bcd_d = bcd_n;
                mag_d      = mag_n;
                ovf_acc_d  = ovf_acc_q | shift_out;
                cnt_d      = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    bcd_d   = bcd_n;
                    blank_d = blank_n;
                    ovf_d   = ovf_acc_q | shift_out;
                    // A zero magnitude never reports negative.
                    neg_d   = sign_q && ((|bcd_n) || ovf_acc_q || shift_out);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            work_bcd_q <= '0;
            mag_q      <= '0;
            sign_q     <= 1'b0;
            ovf_acc_q  <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            blank_q    <= BLANK_RST;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_bcd_q <= work_bcd_d;
            mag_q      <= mag_d;
            sign_q     <= sign_d;
            ovf_acc_q  <= ovf_acc_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            blank_q    <= blank_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
        end
    end

    assign Busy  = busy_q;
    assign Done  = done_q;
    assign Bcd   = bcd_q;
    assign Blank = blank_q;
    assign Neg   = neg_q;
    assign Ovf   = ovf_q;

endmodule

// File: tb/tb_calc_bin2bcd_seq.sv
// Directed bench: default, signed and 4-digit converters share one stimulus stream.
module tb_calc_bin2bcd_seq;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [16:0] Bin = '0;

    logic        busy_a, done_a, blank_dummy;
    logic [23:0] bcd_a;
    logic [5:0]  blank_a;
    logic        neg_a, ovf_a;

    logic        busy_s, done_s;
    logic [23:0] bcd_s;
    logic [5:0]  blank_s;
    logic        neg_s, ovf_s;

    logic        busy_d, done_d;
    logic [15:0] bcd_d;
    logic [3:0]  blank_d;
    logic        neg_d, ovf_d;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    calc_bin2bcd_seq u_dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Bin(Bin),
        .Busy(busy_a), .Done(done_a), .Bcd(bcd_a), .Blank(blank_a), .Neg(neg_a), .Ovf(ovf_a)
    );

    calc_bin2bcd_seq #(.W(17), .DIGITS(6), .SIGNED(1)) u_sgn (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Bin(Bin),
        .Busy(busy_s), .Done(done_s), .Bcd(bcd_s), .Blank(blank_s), .Neg(neg_s), .Ovf(ovf_s)
    );

    calc_bin2bcd_seq #(.W(17), .DIGITS(4), .SIGNED(0)) u_d4 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Bin(Bin),
        .Busy(busy_d), .Done(done_d), .Bcd(bcd_d), .Blank(blank_d), .Neg(neg_d), .Ovf(ovf_d)
    );

    assign blank_dummy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launches one conversion; returns at the negedge of the Done cycle (cycle index in lat).
    task automatic conv(input logic [16:0] v, output int lat);
        @(posedge Clk); #1;
        Start = 1'b1;
        Bin   = v;
        @(posedge Clk); #1;
        Start = 1'b0;
        Bin   = '0;
        lat   = 1;
        @(negedge Clk);
        while (!done_a && lat < 60) begin
            @(negedge Clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int dones;
        int gaps;
        int late_busy;

        repeat (3) @(negedge Clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_bcd", 32'(bcd_a), 32'h000000);
        check("rst_blank", 32'(blank_a), 32'b111110);
        check("rst_neg_ovf", {30'd0, neg_a, ovf_a}, 32'd0);
        check("rst_blank_d4", 32'(blank_d), 32'b1110);
        @(posedge Clk); #1;
        Reset = 1'b0;

        conv(17'd0, lat);
        check("zero_latency", 32'(lat), 32'd18);
        check("zero_bcd", 32'(bcd_a), 32'h000000);
        check("zero_blank", 32'(blank_a), 32'b111110);
        check("zero_neg_ovf", {30'd0, neg_a, ovf_a}, 32'd0);
        @(negedge Clk);
        check("zero_busy_after", 32'(busy_a), 32'd0);

        conv(17'd131071, lat);
        check("max_latency", 32'(lat), 32'd18);
        check("max_bcd", 32'(bcd_a), 32'h131071);
        check("max_blank", 32'(blank_a), 32'b000000);
        check("max_ovf", 32'(ovf_a), 32'd0);

        conv(17'd12345, lat);
        check("v12345_bcd", 32'(bcd_a), 32'h012345);
        check("v12345_blank", 32'(blank_a), 32'b100000);

        conv(17'h1FFFF, lat);
        check("sgn_m1_neg", 32'(neg_s), 32'd1);
        check("sgn_m1_bcd", 32'(bcd_s), 32'h000001);
        check("sgn_m1_blank", 32'(blank_s), 32'b111110);
        check("uns_1ffff_neg", 32'(neg_a), 32'd0);

        conv(17'h10000, lat);
        check("sgn_min_neg", 32'(neg_s), 32'd1);
        check("sgn_min_bcd", 32'(bcd_s), 32'h065536);

        conv(17'h0FFFF, lat);
        check("sgn_pos_neg", 32'(neg_s), 32'd0);
        check("sgn_pos_bcd", 32'(bcd_s), 32'h065535);

        conv(17'd10000, lat);
        check("d4_ovf_flag", 32'(ovf_d), 32'd1);
        check("d4_ovf_bcd", 32'(bcd_d), 32'h0000);

        conv(17'd9999, lat);
        check("d4_9999_ovf", 32'(ovf_d), 32'd0);
        check("d4_9999_bcd", 32'(bcd_d), 32'h9999);
        check("d4_9999_blank", 32'(blank_d), 32'b0000);

        // Start pulses during SHIFT and during DONE must be dropped.
        @(posedge Clk); #1;
        Start = 1'b1;
        Bin   = 17'd500;
        dones = 0;
        gaps = 0;
        late_busy = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge Clk); #1;
            Start = (c == 5 || c == 18);
            Bin   = 17'd777;
            @(negedge Clk);
            if (c <= 18 && !busy_a) gaps++;
            if (c >= 19 && busy_a) late_busy++;
            if (done_a) dones++;
        end
        Start = 1'b0;
        check("ign_done_count", 32'(dones), 32'd1);
        check("ign_busy_gaps", 32'(gaps), 32'd0);
        check("ign_busy_late", 32'(late_busy), 32'd0);
        check("ign_bcd", 32'(bcd_a), 32'h000500);

        // Reset in the middle of a conversion.
        @(posedge Clk); #1;
        Start = 1'b1;
        Bin   = 17'd4321;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (8) @(posedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_bcd", 32'(bcd_a), 32'h000000);
        check("mid_rst_blank", 32'(blank_a), 32'b111110);
        check("mid_rst_done_neg_ovf", {29'd0, done_a, neg_a, ovf_a}, 32'd0);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge Clk);
            if (done_a) dones++;
        end
        check("mid_rst_no_done", 32'(dones), 32'd0);

        conv(17'd4321, lat);
        check("post_rst_latency", 32'(lat), 32'd18);
        check("post_rst_bcd", 32'(bcd_a), 32'h004321);
        check("post_rst_blank", 32'(blank_a), 32'b110000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
